stack_op_sequencer: RTL and testbench

- Command-level controller for DataStackSystem. It accepts one stack operation at a time over a valid/ready handshake and expands it into the per-cycle tr_src, tr_write, reg_write and dp_inc strobe sequence.
- Tracks stack depth and rejects overflow, underflow and illegal ops before any datapath strobe fires.
- Sits between the instruction decode/control unit and DataStackSystem.

---
 rtl/stack_op_sequencer_if.sv | 37 +++
 rtl/stack_op_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_stack_op_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// stack_op_sequencer_if
//   Command/response bundle between the decode/control unit (master) and
//   the stack operation sequencer (slave).
//
//   cmd_valid  master -> slave  command present
//   cmd_ready  slave -> master  sequencer can accept a command (IDLE only)
//   cmd_op     master -> slave  0 NOP,1 PUSH,2 POP,3 DUP,4 SWAP,5 BINOP,
//                               6 CLEAR,7 illegal
//   cmd_imm    master -> slave  PUSH immediate
//   rsp_data   slave -> master  last popped value
//   done       slave -> master  pulse on the final cycle of an accepted command
//   err        slave -> master  pulse on a rejected command
//   err_code   slave -> master  01 overflow, 10 underflow, 11 illegal
// ---------------------------------------------------------------------------
interface stack_op_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_imm;
  logic [WIDTH-1:0] rsp_data;
  logic             done;
  logic             err;
  logic [1:0]       err_code;

  modport master (
    output cmd_valid, cmd_op, cmd_imm,
    input  cmd_ready, rsp_data, done, err, err_code
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_imm,
    output cmd_ready, rsp_data, done, err, err_code
  );
endinterface

// File: rtl/stack_op_sequencer.sv
// ---------------------------------------------------------------------------
// stack_op_sequencer
//   Accepts one stack command at a time and expands it into the per-cycle
//   strobe sequence that drives DataStackSystem (TR register, register file
//   and data pointer). Tracks the item count so overflow, underflow and
//   illegal opcodes are rejected before any datapath strobe fires.
//
//   Stack layout assumed in DataStackSystem: TR holds the top item, the
//   register file entry at DP holds NOS, DP moves by one per push/pop of the
//   register-file part of the stack.
//
// Ports
//   CLK        in   rising-edge clock
//   reset_n    in   synchronous active-low reset
//   bus        slave command/response interface (stack_op_sequencer_if)
//   tr_value   in   current TR contents (source for popped data)
//   tr_src_a   out  immediate latched at accept (TR mux input a)
//   tr_src     out  TR mux select: 0 imm, 1 NOS, 2 ALU
//   tr_write   out  TR load strobe
//   reg_write  out  register file write of TR at DP
//   dp_inc     out  00 hold, 01 DP+1, 10 DP-1
//   ds_reset   out  active-high reset to DataStackSystem
//   depth      out  current item count
// ---------------------------------------------------------------------------
module stack_op_sequencer #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int DEPTH_W = 5
) (
  input  logic                 CLK,
  input  logic                 reset_n,
  stack_op_sequencer_if.slave  bus,
  input  logic [WIDTH-1:0]     tr_value,
  output logic [WIDTH-1:0]     tr_src_a,
  output logic [2:0]           tr_src,
  output logic                 tr_write,
  output logic                 reg_write,
  output logic [1:0]           dp_inc,
  output logic                 ds_reset,
  output logic [DEPTH_W-1:0]   depth
);

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_BINOP = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  localparam logic [2:0] SRC_IMM = 3'd0;
  localparam logic [2:0] SRC_NOS = 3'd1;
  localparam logic [2:0] SRC_ALU = 3'd2;

  localparam logic [1:0] DP_HOLD = 2'b00;
  localparam logic [1:0] DP_UP   = 2'b01;
  localparam logic [1:0] DP_DOWN = 2'b10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OVER  = 2'b01;
  localparam logic [1:0] ERR_UNDER = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DEPTH_TWO = DEPTH_W'(2);

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    INC,
    WR,
    LD,
    DEC,
    SW,
    ERR
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [2:0]           op_q;
  logic [1:0]           err_code_q;
  logic [WIDTH-1:0]     rsp_q;
  logic                 accept;
  logic [1:0]           check_code;
  logic                 done_c;
  logic                 err_c;

  // Legality of a command given the item count at the moment of accept.
  function automatic logic [1:0] legality(input logic [2:0]         op,
                                          input logic [DEPTH_W-1:0] d);
    logic [1:0] code;
    code = ERR_NONE;
    case (op)
      OP_PUSH:           if (d == DEPTH_MAX) code = ERR_OVER;
      OP_DUP:            if (d == DEPTH_MAX) code = ERR_OVER;
                         else if (d == '0)   code = ERR_UNDER;
      OP_POP:            if (d == '0)        code = ERR_UNDER;
      OP_SWAP, OP_BINOP: if (d < DEPTH_TWO)  code = ERR_UNDER;
      3'd7:              code = ERR_ILL;
      default:           code = ERR_NONE;
    endcase
    return code;
  endfunction

  // Item count after a completed command, clamped to [0, DEPTH] so a
  // corrupted op register can never make the counter wrap.
  function automatic logic [DEPTH_W-1:0] depth_after(input logic [2:0]         op,
                                                     input logic [DEPTH_W-1:0] d);
    logic [DEPTH_W-1:0] n;
    n = d;
    case (op)
      OP_PUSH, OP_DUP:  if (d != DEPTH_MAX) n = d + DEPTH_ONE;
      OP_POP, OP_BINOP: if (d != '0)        n = d - DEPTH_ONE;
      OP_CLEAR:         n = '0;
      default:          n = d;
    endcase
    return n;
  endfunction

  assign accept     = (state == IDLE) && bus.cmd_valid;
  assign check_code = legality(bus.cmd_op, depth);

  // State register and command/result latches
  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state      <= INIT;
      op_q       <= OP_NOP;
      err_code_q <= ERR_NONE;
      tr_src_a   <= '0;
      rsp_q      <= '0;
      depth      <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op_q       <= bus.cmd_op;
        err_code_q <= check_code;
        tr_src_a   <= bus.cmd_imm;
      end
      // A POP captures TR either in its single WR cycle (depth 1) or in the
      // LD cycle, before NOS is moved up into TR.
      if (op_q == OP_POP && (state == WR || state == LD)) begin
        rsp_q <= tr_value;
      end
      if (done_c) begin
        depth <= depth_after(op_q, depth);
      end
    end
  end

  // Next-state decode; the route taken from IDLE is fixed at accept using
  // the depth seen at that moment.
  always_comb begin
    state_next = state;
    case (state)
      INIT: state_next = IDLE;
      IDLE: begin
        if (accept) begin
          if (check_code != ERR_NONE) begin
            state_next = ERR;
          end else begin
            case (bus.cmd_op)
              OP_PUSH:  state_next = (depth == '0) ? WR : INC;
              OP_POP:   state_next = (depth == DEPTH_ONE) ? WR : LD;
              OP_DUP:   state_next = INC;
              OP_SWAP:  state_next = SW;
              OP_BINOP: state_next = LD;
              default:  state_next = WR;
            endcase
          end
        end
      end
      INC:     state_next = WR;
      LD:      state_next = DEC;
      WR:      state_next = IDLE;
      DEC:     state_next = IDLE;
      SW:      state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Strobe decode. WR is the shared single-cycle finishing state; what it
  // drives depends on the latched op (NOP, short POP and CLEAR also end here).
  always_comb begin
    tr_src    = SRC_IMM;
    tr_write  = 1'b0;
    reg_write = 1'b0;
    dp_inc    = DP_HOLD;
    ds_reset  = 1'b0;
    done_c    = 1'b0;
    err_c     = 1'b0;
    case (state)
      INIT: ds_reset = 1'b1;
      INC:  dp_inc   = DP_UP;
      WR: begin
        done_c = 1'b1;
        case (op_q)
          OP_PUSH: begin
            tr_write  = 1'b1;
            // The first item lives only in TR; later pushes spill TR first.
            reg_write = (depth != '0);
          end
          OP_DUP:   reg_write = 1'b1;
          OP_CLEAR: ds_reset  = 1'b1;
          default:  ;
        endcase
      end
      LD: begin
        tr_write = 1'b1;
        tr_src   = (op_q == OP_BINOP) ? SRC_ALU : SRC_NOS;
      end
      DEC: begin
        dp_inc = DP_DOWN;
        done_c = 1'b1;
      end
      SW: begin
        // Both writes sample pre-edge TR and NOS, so they exchange.
        reg_write = 1'b1;
        tr_write  = 1'b1;
        tr_src    = SRC_NOS;
        done_c    = 1'b1;
      end
      ERR:     err_c = 1'b1;
      default: ;
    endcase
  end

  assign bus.cmd_ready = (state == IDLE);
  assign bus.done      = done_c;
  assign bus.err       = err_c;
  assign bus.err_code  = err_c ? err_code_q : ERR_NONE;
  assign bus.rsp_data  = rsp_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
module tb_stack_op_sequencer;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 16;
  localparam int DEPTH_W = 5;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  always #5 CLK = ~CLK;

  stack_op_sequencer_if #(.WIDTH(WIDTH)) bus ();

  logic [WIDTH-1:0]   tr_value;
  logic [WIDTH-1:0]   tr_src_a;
  logic [2:0]         tr_src;
  logic               tr_write;
  logic               reg_write;
  logic [1:0]         dp_inc;
  logic               ds_reset;
  logic [DEPTH_W-1:0] depth;

  stack_op_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .CLK       (CLK),
    .reset_n   (reset_n),
    .bus       (bus),
    .tr_value  (tr_value),
    .tr_src_a  (tr_src_a),
    .tr_src    (tr_src),
    .tr_write  (tr_write),
    .reg_write (reg_write),
    .dp_inc    (dp_inc),
    .ds_reset  (ds_reset),
    .depth     (depth)
  );

  // Behavioural DataStackSystem: TR, register file at DP, ALU = TR + NOS.
  logic [WIDTH-1:0] m_regs [16];
  logic [3:0]       m_dp;
  logic [WIDTH-1:0] m_tr;
  logic [WIDTH-1:0] read_data;
  logic [WIDTH-1:0] alu;
  assign read_data = m_regs[m_dp];
  assign alu       = m_tr + read_data;
  assign tr_value  = m_tr;

  always @(posedge CLK) begin
    if (ds_reset) begin
      m_dp <= '0;
      m_tr <= '0;
    end else begin
      if (reg_write) m_regs[m_dp] <= m_tr;
      if (tr_write) begin
        case (tr_src)
          3'd0:    m_tr <= tr_src_a;
          3'd1:    m_tr <= read_data;
          3'd2:    m_tr <= alu;
          default: m_tr <= 'x;
        endcase
      end
      if (dp_inc == 2'b01) m_dp <= m_dp + 4'd1;
      else if (dp_inc == 2'b10) m_dp <= m_dp - 4'd1;
    end
  end

  // Reference: q[0] is the top of stack.
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_rsp = '0;
  int               last_wait = 0;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] imm);
    int               d;
    int               w;
    bit               fin;
    bit               seq_ok;
    logic [1:0]       code;
    logic [7:0]       exp_seq[$];
    logic [7:0]       got_seq[$];
    logic [1:0]       got_de;
    logic [1:0]       got_code;
    logic [WIDTH-1:0] t;
    d = q.size();
    code = 2'b00;
    got_de = 2'b00;
    got_code = 2'b00;
    if (op == 3'd7) code = 2'b11;
    else if ((op == 3'd1 || op == 3'd3) && d == DEPTH) code = 2'b01;
    else if (((op == 3'd2 || op == 3'd3) && d == 0) || ((op == 3'd4 || op == 3'd5) && d < 2)) code = 2'b10;
    // expected strobe word per cycle: {ds_reset, tr_write, reg_write, tr_src, dp_inc}
    if (code != 2'b00) exp_seq.push_back(8'h00);
    else begin
      case (op)
        3'd1: if (d == 0) exp_seq.push_back({1'b0, 1'b1, 1'b0, 3'd0, 2'b00});
              else begin exp_seq.push_back(8'h01); exp_seq.push_back({1'b0, 1'b1, 1'b1, 3'd0, 2'b00}); end
        3'd2: if (d == 1) exp_seq.push_back(8'h00);
              else begin exp_seq.push_back({1'b0, 1'b1, 1'b0, 3'd1, 2'b00}); exp_seq.push_back(8'h02); end
        3'd3: begin exp_seq.push_back(8'h01); exp_seq.push_back({1'b0, 1'b0, 1'b1, 3'd0, 2'b00}); end
        3'd4: exp_seq.push_back({1'b0, 1'b1, 1'b1, 3'd1, 2'b00});
        3'd5: begin exp_seq.push_back({1'b0, 1'b1, 1'b0, 3'd2, 2'b00}); exp_seq.push_back(8'h02); end
        3'd6: exp_seq.push_back(8'h80);
        default: exp_seq.push_back(8'h00);
      endcase
    end

    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 20) begin
      @(posedge CLK); #1; w++;
    end
    last_wait = w;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL ready_wait op=%0d cmd_ready=%b want 1", op, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_imm = imm;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    fin = 0;
    for (int c = 0; c < 8 && !fin; c++) begin
      got_seq.push_back({ds_reset, tr_write, reg_write, (tr_write ? tr_src : 3'd0), dp_inc});
      checks++;
      if (bus.cmd_ready !== 1'b0) begin
        errors++; $display("FAIL busy_ready op=%0d cycle=%0d cmd_ready=%b want 0", op, c, bus.cmd_ready);
      end
      if (bus.done === 1'b1 || bus.err === 1'b1) begin
        fin = 1; got_de = {bus.done, bus.err}; got_code = bus.err_code;
      end else begin
        @(posedge CLK); #1;
      end
    end
    checks++;
    if (!fin) begin
      errors++; $display("FAIL finish_timeout op=%0d depth=%0d no done/err within 8 cycles", op, d);
    end
    seq_ok = (got_seq.size() == exp_seq.size());
    if (seq_ok) foreach (exp_seq[i]) if (got_seq[i] !== exp_seq[i]) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++; $display("FAIL strobe_seq op=%0d depth=%0d got=%p want=%p", op, d, got_seq, exp_seq);
    end
    checks++;
    if (got_de !== {code == 2'b00, code != 2'b00}) begin
      errors++; $display("FAIL done_err op=%0d depth=%0d got {done,err}=%b want %b", op, d, got_de, {code == 2'b00, code != 2'b00});
    end
    if (code != 2'b00) begin
      checks++;
      if (got_code !== code) begin
        errors++; $display("FAIL err_code op=%0d depth=%0d got=%b want=%b", op, d, got_code, code);
      end
    end else begin
      case (op)
        3'd1: q.push_front(imm);
        3'd2: begin exp_rsp = q[0]; void'(q.pop_front()); end
        3'd3: q.push_front(q[0]);
        3'd4: begin t = q[0]; q[0] = q[1]; q[1] = t; end
        3'd5: begin t = q[0] + q[1]; void'(q.pop_front()); void'(q.pop_front()); q.push_front(t); end
        3'd6: q.delete();
        default: ;
      endcase
    end

    @(posedge CLK); #1;
    checks++;
    if (depth !== DEPTH_W'(q.size())) begin
      errors++; $display("FAIL depth op=%0d got=%0d want=%0d", op, depth, q.size());
    end
    checks++;
    if (bus.rsp_data !== exp_rsp) begin
      errors++; $display("FAIL rsp_data op=%0d got=%h want=%h", op, bus.rsp_data, exp_rsp);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
      errors++; $display("FAIL after_ready op=%0d got ready/done/err=%b%b%b want 100", op, bus.cmd_ready, bus.done, bus.err);
    end
    if (q.size() >= 1) begin
      checks++;
      if (m_tr !== q[0]) begin
        errors++; $display("FAIL tr_value op=%0d got=%h want=%h", op, m_tr, q[0]);
      end
    end
    if (q.size() >= 2) begin
      checks++;
      if (read_data !== q[1]) begin
        errors++; $display("FAIL nos_value op=%0d got=%h want=%h", op, read_data, q[1]);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++;
    if ({ds_reset, bus.cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL reset_ctrl got ds_reset/cmd_ready=%b%b want 10", ds_reset, bus.cmd_ready);
    end
    checks++;
    if ({tr_write, reg_write, dp_inc, tr_src, bus.done, bus.err} !== 9'd0) begin
      errors++; $display("FAIL reset_strobes got tw=%b rw=%b dp=%b src=%0d done=%b err=%b want all 0",
                         tr_write, reg_write, dp_inc, tr_src, bus.done, bus.err);
    end
    checks++;
    if (depth !== '0 || bus.rsp_data !== '0 || tr_src_a !== '0) begin
      errors++; $display("FAIL reset_regs got depth=%0d rsp=%h src_a=%h want 0", depth, bus.rsp_data, tr_src_a);
    end
    reset_n = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({ds_reset, bus.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL post_reset got ds_reset/cmd_ready=%b%b want 01", ds_reset, bus.cmd_ready);
    end
    q.delete();
    exp_rsp = '0;
  endtask

  task automatic test_directed();
    run_cmd(3'd1, 16'd4);
    run_cmd(3'd1, 16'd2);
    run_cmd(3'd4, 16'd0);
    run_cmd(3'd5, 16'd0);
    checks++;
    if (m_tr !== 16'd6) begin
      errors++; $display("FAIL binop_tr got=%0d want=6", m_tr);
    end
    run_cmd(3'd2, 16'd0);
    run_cmd(3'd2, 16'd0);
    run_cmd(3'd0, 16'd0);
    run_cmd(3'd3, 16'd0);
    run_cmd(3'd1, 16'h00a5);
    run_cmd(3'd3, 16'd0);
    run_cmd(3'd2, 16'd0);
    run_cmd(3'd6, 16'd0);
  endtask

  task automatic test_overflow();
    run_cmd(3'd6, 16'd0);
    for (int i = 0; i < DEPTH; i++) run_cmd(3'd1, 16'($urandom));
    run_cmd(3'd1, 16'd9);
    run_cmd(3'd3, 16'd0);
    run_cmd(3'd7, 16'd0);
    run_cmd(3'd5, 16'd0);
    run_cmd(3'd6, 16'd0);
    run_cmd(3'd4, 16'd0);
    run_cmd(3'd3, 16'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_cmd(3'd1, 16'(i + 100));
      checks++;
      if (last_wait !== 0) begin
        errors++; $display("FAIL back_to_back i=%0d waited=%0d want 0", i, last_wait);
      end
    end
  endtask

  task automatic test_busy_valid();
    int d0;
    run_cmd(3'd6, 16'd0);
    run_cmd(3'd1, 16'd5);
    d0 = q.size();
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_imm = 16'd7;
    @(posedge CLK); #1;
    checks++;
    if (bus.cmd_ready !== 1'b0 || dp_inc !== 2'b01) begin
      errors++; $display("FAIL busy_inc got ready=%b dp_inc=%b want 0/01", bus.cmd_ready, dp_inc);
    end
    @(posedge CLK); #1;
    checks++;
    if (bus.cmd_ready !== 1'b0 || bus.done !== 1'b1) begin
      errors++; $display("FAIL busy_wr got ready=%b done=%b want 0/1", bus.cmd_ready, bus.done);
    end
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    q.push_front(16'd7);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL busy_release got ready=%b want 1", bus.cmd_ready);
    end
    @(posedge CLK); #1;
    checks++;
    if (depth !== DEPTH_W'(d0 + 1) || bus.cmd_ready !== 1'b1 || bus.done !== 1'b0) begin
      errors++; $display("FAIL busy_single got depth=%0d ready=%b done=%b want %0d/1/0", depth, bus.cmd_ready, bus.done, d0 + 1);
    end
  endtask

  task automatic test_reset_mid();
    run_cmd(3'd6, 16'd0);
    run_cmd(3'd1, 16'h0011);
    bus.cmd_valid = 1'b1; bus.cmd_op = 3'd1; bus.cmd_imm = 16'h0022;
    @(posedge CLK); #1;
    bus.cmd_valid = 1'b0;
    checks++;
    if (dp_inc !== 2'b01) begin
      errors++; $display("FAIL mid_inc got dp_inc=%b want 01", dp_inc);
    end
    reset_n = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if ({tr_write, reg_write, dp_inc, bus.done, bus.err, bus.cmd_ready} !== 7'd0) begin
      errors++; $display("FAIL mid_strobes got tw=%b rw=%b dp=%b done=%b err=%b ready=%b want all 0",
                         tr_write, reg_write, dp_inc, bus.done, bus.err, bus.cmd_ready);
    end
    checks++;
    if (depth !== '0 || ds_reset !== 1'b1) begin
      errors++; $display("FAIL mid_state got depth=%0d ds_reset=%b want 0/1", depth, ds_reset);
    end
    reset_n = 1'b1;
    @(posedge CLK); #1;
    q.delete();
    exp_rsp = '0;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL mid_recover got ready=%b want 1", bus.cmd_ready);
    end
    run_cmd(3'd1, 16'h0033);
  endtask

  task automatic test_random();
    logic [2:0] op;
    for (int i = 0; i < 250; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd6 && $urandom_range(0, 3) != 0) op = 3'd1;
      run_cmd(op, 16'($urandom));
    end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_imm   = '0;
    test_reset();
    test_directed();
    test_overflow();
    test_back_to_back();
    test_busy_valid();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
